// File: rtl/case_6_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | case_6_pkg : shared state encoding, accumulator types, sat helper  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package case_6_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam int ACC_WIDTH_DEF  = 12;
  localparam int PROD_WIDTH_DEF = 6;

  typedef logic signed [ACC_WIDTH_DEF-1:0]  acc_t;
  typedef logic signed [PROD_WIDTH_DEF-1:0] prod_t;

  // Returns {sat_flag, clamped_sum}; overflow shows up as disagreeing top two bits.
  function automatic logic [ACC_WIDTH_DEF:0] sat_add(input acc_t acc, input prod_t prod);
    logic [ACC_WIDTH_DEF:0] wide;
    wide = {acc[ACC_WIDTH_DEF-1], acc}
         + {{(ACC_WIDTH_DEF-PROD_WIDTH_DEF+1){prod[PROD_WIDTH_DEF-1]}}, prod};
    if (wide[ACC_WIDTH_DEF] != wide[ACC_WIDTH_DEF-1]) begin
      if (wide[ACC_WIDTH_DEF])
        return {1'b1, 1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};
      else
        return {1'b1, 1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
    end
    return {1'b0, wide[ACC_WIDTH_DEF-1:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/case_6_prod_accum_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | case_6_prod_accum_if : product-in / frame-result-out handshakes    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface case_6_prod_accum_if #(
  parameter int PROD_WIDTH = 6,
  parameter int ACC_WIDTH  = 12,
  parameter int ACC_LEN    = 8
);
  localparam int CNT_WIDTH = $clog2(ACC_LEN + 1);

  logic signed [PROD_WIDTH-1:0] in_prod;
  logic                         in_valid;
  logic                         in_last;
  logic                         in_ready;
  logic signed [ACC_WIDTH-1:0]  out_sum;
  logic [CNT_WIDTH-1:0]         out_count;
  logic                         out_sat;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output in_prod, in_valid, in_last, out_ready,
    input  in_ready, out_sum, out_count, out_sat, out_valid
  );

  modport slave (
    input  in_prod, in_valid, in_last, out_ready,
    output in_ready, out_sum, out_count, out_sat, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/case_6_sat_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | case_6_sat_adder : combinational saturating signed acc + product   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module case_6_sat_adder #(
  parameter int ACC_WIDTH  = 12,
  parameter int PROD_WIDTH = 6
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic signed [PROD_WIDTH-1:0] prod,
  output logic signed [ACC_WIDTH-1:0]  sum,
  output logic                         sat
);

  logic [ACC_WIDTH:0] wide;

  always_comb begin
    wide = {acc[ACC_WIDTH-1], acc}
         + {{(ACC_WIDTH-PROD_WIDTH+1){prod[PROD_WIDTH-1]}}, prod};
    // One extra bit is enough: disagreeing top bits means the true sum left the range.
    sat  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
    if (!sat)
      sum = wide[ACC_WIDTH-1:0];
    else if (wide[ACC_WIDTH])
      sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

endmodule
`default_nettype wire

// File: rtl/case_6_prod_accum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | case_6_prod_accum : frames of signed products into saturating sums |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module case_6_prod_accum
  import case_6_pkg::*;
#(
  parameter int PROD_WIDTH = 6,
  parameter int ACC_WIDTH  = 12,
  parameter int ACC_LEN    = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  case_6_prod_accum_if.slave   bus
);

  localparam int CNT_WIDTH = $clog2(ACC_LEN + 1);

  logic [1:0]                  state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        sat_q, sat_d;
  logic signed [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CNT_WIDTH-1:0]        out_count_q, out_count_d;
  logic                        out_sat_q, out_sat_d;

  logic                        in_ready;
  logic                        accept;
  logic                        in_idle;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic [CNT_WIDTH-1:0]        cnt_inc;
  logic                        sat_base;
  logic                        frame_done;
  logic signed [ACC_WIDTH-1:0] add_sum;
  logic                        add_sat;

  case_6_sat_adder #(
    .ACC_WIDTH  (ACC_WIDTH),
    .PROD_WIDTH (PROD_WIDTH)
  ) u_sat_adder (
    .acc  (acc_base),
    .prod (bus.in_prod),
    .sum  (add_sum),
    .sat  (add_sat)
  );

  always_comb begin
    in_idle    = (state_q == ST_IDLE);
    in_ready   = in_idle || (state_q == ST_ACCUM);
    accept     = bus.in_valid && in_ready;
    // A frame always starts from zero, whatever the registers hold.
    acc_base   = in_idle ? '0 : acc_q;
    sat_base   = in_idle ? 1'b0 : sat_q;
    cnt_inc    = (in_idle ? '0 : cnt_q) + CNT_WIDTH'(1);
    frame_done = bus.in_last || (cnt_inc == CNT_WIDTH'(ACC_LEN));
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          sat_d = sat_base | add_sat;
          if (frame_done) begin
            state_d     = ST_HOLD;
            out_sum_d   = add_sum;
            out_count_d = cnt_inc;
            out_sat_d   = sat_base | add_sat;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_case_6_prod_accum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_case_6_prod_accum : three configurations vs. a frame-level model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_case_6_prod_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance 0: defaults, 1: ACC_WIDTH=7, 2: ACC_LEN=1
  bit drv_rst   [3];
  bit drv_valid [3];
  bit drv_last  [3];
  bit drv_ready [3];
  int drv_prod  [3];

  int aw   [3] = '{12, 7, 12};
  int alen [3] = '{8, 8, 1};

  case_6_prod_accum_if #(.PROD_WIDTH(6), .ACC_WIDTH(12), .ACC_LEN(8)) if0 ();
  case_6_prod_accum_if #(.PROD_WIDTH(6), .ACC_WIDTH(7),  .ACC_LEN(8)) if1 ();
  case_6_prod_accum_if #(.PROD_WIDTH(6), .ACC_WIDTH(12), .ACC_LEN(1)) if2 ();

  case_6_prod_accum #(.PROD_WIDTH(6), .ACC_WIDTH(12), .ACC_LEN(8)) u0 (
    .ap_clk(clk), .ap_rst_n(drv_rst[0]), .bus(if0.slave));
  case_6_prod_accum #(.PROD_WIDTH(6), .ACC_WIDTH(7), .ACC_LEN(8)) u1 (
    .ap_clk(clk), .ap_rst_n(drv_rst[1]), .bus(if1.slave));
  case_6_prod_accum #(.PROD_WIDTH(6), .ACC_WIDTH(12), .ACC_LEN(1)) u2 (
    .ap_clk(clk), .ap_rst_n(drv_rst[2]), .bus(if2.slave));

  assign if0.in_prod = drv_prod[0][5:0];
  assign if1.in_prod = drv_prod[1][5:0];
  assign if2.in_prod = drv_prod[2][5:0];
  assign if0.in_valid = drv_valid[0];
  assign if1.in_valid = drv_valid[1];
  assign if2.in_valid = drv_valid[2];
  assign if0.in_last = drv_last[0];
  assign if1.in_last = drv_last[1];
  assign if2.in_last = drv_last[2];
  assign if0.out_ready = drv_ready[0];
  assign if1.out_ready = drv_ready[1];
  assign if2.out_ready = drv_ready[2];

  logic signed [31:0] d_sum [3];
  logic signed [31:0] d_cnt [3];
  logic               d_sat [3];
  logic               d_ov  [3];
  logic               d_ir  [3];

  assign d_sum[0] = 32'(if0.out_sum);
  assign d_sum[1] = 32'(if1.out_sum);
  assign d_sum[2] = 32'(if2.out_sum);
  assign d_cnt[0] = 32'(if0.out_count);
  assign d_cnt[1] = 32'(if1.out_count);
  assign d_cnt[2] = 32'(if2.out_count);
  assign d_sat[0] = if0.out_sat;
  assign d_sat[1] = if1.out_sat;
  assign d_sat[2] = if2.out_sat;
  assign d_ov[0]  = if0.out_valid;
  assign d_ov[1]  = if1.out_valid;
  assign d_ov[2]  = if2.out_valid;
  assign d_ir[0]  = if0.in_ready;
  assign d_ir[1]  = if1.in_ready;
  assign d_ir[2]  = if2.in_ready;

  // Frame-level model: running sum, beat count, sticky sat, and one pending result.
  int m_acc  [3];
  int m_cnt  [3];
  bit m_sat  [3];
  bit m_pend [3];
  int m_osum [3];
  int m_ocnt [3];
  bit m_osat [3];

  typedef struct {
    int inst;
    int sum;
    int cnt;
    bit sat;
  } res_t;
  res_t resq[$];

  task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampf(input int s, input int w, output bit f);
    int mx;
    int mn;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    f  = 1'b0;
    if (s > mx) begin
      f = 1'b1;
      return mx;
    end
    if (s < mn) begin
      f = 1'b1;
      return mn;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!drv_rst[k]) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_pend[k] = 0;
        m_osum[k] = 0; m_ocnt[k] = 0; m_osat[k] = 0;
      end else if (m_pend[k]) begin
        if (drv_ready[k]) begin
          resq.push_back('{k, m_osum[k], m_ocnt[k], m_osat[k]});
          m_pend[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
        end
      end else if (drv_valid[k]) begin
        bit f;
        m_acc[k] = clampf(m_acc[k] + drv_prod[k], aw[k], f);
        m_sat[k] = m_sat[k] | f;
        m_cnt[k] = m_cnt[k] + 1;
        if (drv_last[k] || m_cnt[k] == alen[k]) begin
          m_pend[k] = 1;
          m_osum[k] = m_acc[k];
          m_ocnt[k] = m_cnt[k];
          m_osat[k] = m_sat[k];
        end
      end
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("in_ready[%0d]", k), 32'(d_ir[k]), m_pend[k] ? 0 : 1);
      chk($sformatf("out_valid[%0d]", k), 32'(d_ov[k]), m_pend[k] ? 1 : 0);
      if (m_pend[k]) begin
        chk($sformatf("out_sum[%0d]", k), d_sum[k], m_osum[k]);
        chk($sformatf("out_count[%0d]", k), d_cnt[k], m_ocnt[k]);
        chk($sformatf("out_sat[%0d]", k), 32'(d_sat[k]), int'(m_osat[k]));
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic beat(input int k, input int p, input bit l);
    bit acc;
    int n;
    n = 0;
    drv_valid[k] = 1'b1;
    drv_prod[k]  = p;
    drv_last[k]  = l;
    do begin
      acc = !m_pend[k];
      @(negedge clk);
      n++;
    end while (!acc && n < 100);
    if (!acc) chk($sformatf("beat_timeout[%0d]", k), 0, 1);
  endtask

  task automatic idle(input int k);
    drv_valid[k] = 1'b0;
    drv_last[k]  = 1'b0;
    drv_prod[k]  = 0;
  endtask

  task automatic expect_res(input string tag, input int k, input int s, input int c, input bit st);
    int idx;
    idx = -1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < resq.size(); i++) begin
      if (resq[i].inst == k) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      chk({tag, "_present"}, 0, 1);
    end else begin
      chk({tag, "_sum"}, resq[idx].sum, s);
      chk({tag, "_count"}, resq[idx].cnt, c);
      chk({tag, "_sat"}, 32'(resq[idx].sat), int'(st));
      resq.delete(idx);
    end
  endtask

  task automatic rand_drive(input int k);
    repeat (1500) begin
      @(negedge clk);
      drv_rst[k]   = ($urandom_range(0, 299) != 0);
      drv_valid[k] = ($urandom_range(0, 3) != 0);
      drv_last[k]  = ($urandom_range(0, 5) == 0);
      drv_prod[k]  = int'($urandom_range(0, 63)) - 32;
      drv_ready[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      drv_rst[k] = 0; drv_valid[k] = 0; drv_last[k] = 0;
      drv_ready[k] = 1; drv_prod[k] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(if0.out_valid), 0);
    chk("rst_in_ready", 32'(if0.in_ready), 1);
    chk("rst_out_sum", d_sum[0], 0);
    chk("rst_out_count", d_cnt[0], 0);
    chk("rst_out_sat", 32'(if0.out_sat), 0);
    for (int k = 0; k < 3; k++) drv_rst[k] = 1;
    @(negedge clk);

    // Full frame closed by the counter
    for (int i = 0; i < 8; i++) beat(0, 3, 1'b0);
    idle(0);
    expect_res("t1", 0, 24, 8, 1'b0);

    // Mixed signs, closed by in_last, then a fresh frame
    beat(0, -32, 1'b0); beat(0, 31, 1'b0); beat(0, -1, 1'b0); beat(0, 5, 1'b1);
    beat(0, 7, 1'b1);
    idle(0);
    expect_res("t2a", 0, 3, 4, 1'b0);
    expect_res("t2b", 0, 7, 1, 1'b0);

    // Saturation at ACC_WIDTH=7
    beat(1, 31, 1'b0); beat(1, 31, 1'b0); beat(1, 31, 1'b0); beat(1, -10, 1'b1);
    beat(1, 1, 1'b0); beat(1, 1, 1'b1);
    idle(1);
    expect_res("t3a", 1, 53, 4, 1'b1);
    expect_res("t3b", 1, 2, 2, 1'b0);

    // Backpressure while the next beat waits
    drv_ready[0] = 1'b0;
    for (int i = 1; i <= 8; i++) beat(0, i, 1'b0);
    fork
      begin
        repeat (5) @(negedge clk);
        drv_ready[0] = 1'b1;
      end
      beat(0, 4, 1'b1);
    join
    idle(0);
    expect_res("t4a", 0, 36, 8, 1'b0);
    expect_res("t4b", 0, 4, 1, 1'b0);

    // Reset mid-frame discards partial sum
    for (int i = 0; i < 3; i++) beat(0, 7, 1'b0);
    idle(0);
    drv_rst[0] = 1'b0;
    @(negedge clk);
    drv_rst[0] = 1'b1;
    chk("t5_rst_valid", 32'(if0.out_valid), 0);
    chk("t5_rst_ready", 32'(if0.in_ready), 1);
    chk("t5_rst_sum", d_sum[0], 0);
    chk("t5_rst_count", d_cnt[0], 0);
    for (int i = 0; i < 8; i++) beat(0, 1, 1'b0);
    idle(0);
    expect_res("t5", 0, 8, 8, 1'b0);

    // ACC_LEN=1: every beat is a frame
    beat(2, 5, 1'b0); beat(2, -6, 1'b0);
    idle(2);
    expect_res("t6a", 2, 5, 1, 1'b0);
    expect_res("t6b", 2, -6, 1, 1'b0);
    chk("leftover_results", resq.size(), 0);

    // Random traffic on all three configurations
    fork
      rand_drive(0);
      rand_drive(1);
      rand_drive(2);
    join
    for (int k = 0; k < 3; k++) begin
      idle(k);
      drv_rst[k] = 1;
      drv_ready[k] = 1;
    end
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
